// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two requester ports and the data-memory bus
// served by dmem_arbiter.
//   req/we/size/addr/wdata_p0/p1 : requester command fields (port 0 = LSU, port 1 = DMA/debug)
//   gnt_p0/p1                    : combinational grant back to each requester
//   resp_valid/rdata/err_p0/p1   : one-cycle response to the owning requester
//   mem_we/mem_a/mem_wd          : memory write enables, address, write data
//   mem_rd                       : memory combinational read data
// The slave modport is the arbiter's view. The master modport is the
// surrounding system, meaning the requesters together with the memory.
interface dmem_arbiter_if;
    logic        req_p0, req_p1;
    logic        we_p0, we_p1;
    logic [1:0]  size_p0, size_p1;
    logic [31:0] addr_p0, addr_p1;
    logic [31:0] wdata_p0, wdata_p1;
    logic        gnt_p0, gnt_p1;
    logic        resp_valid_p0, resp_valid_p1;
    logic [31:0] rdata_p0, rdata_p1;
    logic        err_p0, err_p1;
    logic [3:0]  mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_p0, req_p1, we_p0, we_p1, size_p0, size_p1,
               addr_p0, addr_p1, wdata_p0, wdata_p1, mem_rd,
        output gnt_p0, gnt_p1, resp_valid_p0, resp_valid_p1,
               rdata_p0, rdata_p1, err_p0, err_p1, mem_we, mem_a, mem_wd
    );

    modport master (
        output req_p0, req_p1, we_p0, we_p1, size_p0, size_p1,
               addr_p0, addr_p1, wdata_p0, wdata_p1, mem_rd,
        input  gnt_p0, gnt_p1, resp_valid_p0, resp_valid_p1,
               rdata_p0, rdata_p1, err_p0, err_p1, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that shares one single-port data memory
// between the core LSU (port 0) and a DMA/debug loader (port 1).
// Each granted access occupies the memory bus for WAIT+1 cycles. Write
// enables are raised only in the last of those cycles. One cycle after that
// last cycle, the owner receives a single-cycle response.
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : dmem_arbiter_if.slave (requester ports plus memory bus)
// Parameter WAIT (0..15) sets the number of extra cycles each access holds the bus.
module dmem_arbiter #(
    parameter int WAIT = 0
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [3:0] WAIT_C = 4'(WAIT);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_p1;
    logic        port_p1, we_p1, err_p1;
    logic [1:0]  size_p1;
    logic [31:0] addr_p1, wdata_p1;
    logic        rr_last;          // 1: port 1 was granted last, so port 0 wins a tie
    logic        vld0_p2, vld1_p2, err0_p2, err1_p2;
    logic [31:0] rdata0_p2, rdata1_p2;

    logic        final_c, grant_ok, gnt0, gnt1;
    logic        s_we;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, rd_c;
    logic [3:0]  mem_we_c;

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] alo);
        case (size)
            2'b00:   access_err = 1'b0;
            2'b01:   access_err = alo[0];
            2'b10:   access_err = (alo != 2'b00);
            default: access_err = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            2'b00:   lane_mask = 4'b0001;
            2'b01:   lane_mask = 4'b0011;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Stage p0: arbitration and request sampling (combinational)
    always_comb begin
        final_c  = (state_q == ACCESS) && (cnt_p1 == WAIT_C);
        grant_ok = !reset && ((state_q == IDLE) || final_c);
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        if (grant_ok) begin
            if (bus.req_p0 && bus.req_p1) begin
                gnt0 = rr_last;
                gnt1 = !rr_last;
            end else begin
                gnt0 = bus.req_p0;
                gnt1 = bus.req_p1;
            end
        end
        state_d = state_q;
        if (gnt0 || gnt1) begin
            state_d = ACCESS;
        end else if (final_c) begin
            state_d = IDLE;
        end
        // Gating the enables to the final cycle gives exactly one write edge per store.
        mem_we_c = 4'b0000;
        if (final_c && we_p1 && !err_p1) begin
            mem_we_c = lane_mask(size_p1);
        end
    end

    assign s_we    = gnt1 ? bus.we_p1    : bus.we_p0;
    assign s_size  = gnt1 ? bus.size_p1  : bus.size_p0;
    assign s_addr  = gnt1 ? bus.addr_p1  : bus.addr_p0;
    assign s_wdata = gnt1 ? bus.wdata_p1 : bus.wdata_p0;
    assign rd_c    = (we_p1 || err_p1) ? 32'h0 : bus.mem_rd;

    // Stage p1: access stage held on the memory bus; stage p2: response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_p1    <= 4'd0;
            rr_last   <= 1'b1;
            port_p1   <= 1'b0;
            we_p1     <= 1'b0;
            err_p1    <= 1'b0;
            size_p1   <= 2'b00;
            addr_p1   <= 32'h0;
            wdata_p1  <= 32'h0;
            vld0_p2   <= 1'b0;
            vld1_p2   <= 1'b0;
            err0_p2   <= 1'b0;
            err1_p2   <= 1'b0;
            rdata0_p2 <= 32'h0;
            rdata1_p2 <= 32'h0;
        end else begin
            state_q <= state_d;
            if (gnt0 || gnt1) begin
                cnt_p1   <= 4'd0;
                rr_last  <= gnt1;
                port_p1  <= gnt1;
                we_p1    <= s_we;
                size_p1  <= s_size;
                addr_p1  <= s_addr;
                wdata_p1 <= s_wdata;
                err_p1   <= access_err(s_size, s_addr[1:0]);
            end else if ((state_q == ACCESS) && !final_c) begin
                cnt_p1 <= cnt_p1 + 4'd1;
            end
            vld0_p2   <= final_c && !port_p1;
            vld1_p2   <= final_c && port_p1;
            err0_p2   <= final_c && !port_p1 && err_p1;
            err1_p2   <= final_c && port_p1 && err_p1;
            rdata0_p2 <= (final_c && !port_p1) ? rd_c : 32'h0;
            rdata1_p2 <= (final_c && port_p1) ? rd_c : 32'h0;
        end
    end

    assign bus.gnt_p0        = gnt0;
    assign bus.gnt_p1        = gnt1;
    assign bus.mem_we        = mem_we_c;
    assign bus.mem_a         = addr_p1;
    assign bus.mem_wd        = wdata_p1;
    assign bus.resp_valid_p0 = vld0_p2;
    assign bus.resp_valid_p1 = vld1_p2;
    assign bus.rdata_p0      = rdata0_p2;
    assign bus.rdata_p1      = rdata1_p2;
    assign bus.err_p0        = err0_p2;
    assign bus.err_p1        = err1_p2;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter.
// Instance 0 runs with WAIT=0 and instance 1 with WAIT=3. Each instance owns a
// byte-addressed memory. In that memory, lanes and data are steered by mem_a[1:0].
module tb_dmem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s [2];
    logic        mem_clr;
    logic        req [2][2];
    logic        wen [2][2];
    logic [1:0]  siz [2][2];
    logic [31:0] adr [2][2];
    logic [31:0] wdt [2][2];
    logic        gnt [2][2];
    logic        rv  [2][2];
    logic [31:0] rdt [2][2];
    logic        erx [2][2];
    logic [3:0]  mwe [2];
    logic [3:0]  we_sh [2];
    logic [31:0] ma [2];
    logic [31:0] mwd [2];
    logic [31:0] wd_sh [2];
    logic [31:0] mem [2][256];
    logic [7:0]  mb [1024];

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter_if bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_arbiter #(.WAIT(g * 3)) u_dut (.clk(clk), .reset(rst_s[g]), .bus(bus[g]));
        assign bus[g].req_p0   = req[g][0];
        assign bus[g].req_p1   = req[g][1];
        assign bus[g].we_p0    = wen[g][0];
        assign bus[g].we_p1    = wen[g][1];
        assign bus[g].size_p0  = siz[g][0];
        assign bus[g].size_p1  = siz[g][1];
        assign bus[g].addr_p0  = adr[g][0];
        assign bus[g].addr_p1  = adr[g][1];
        assign bus[g].wdata_p0 = wdt[g][0];
        assign bus[g].wdata_p1 = wdt[g][1];
        assign gnt[g][0]       = bus[g].gnt_p0;
        assign gnt[g][1]       = bus[g].gnt_p1;
        assign rv[g][0]        = bus[g].resp_valid_p0;
        assign rv[g][1]        = bus[g].resp_valid_p1;
        assign rdt[g][0]       = bus[g].rdata_p0;
        assign rdt[g][1]       = bus[g].rdata_p1;
        assign erx[g][0]       = bus[g].err_p0;
        assign erx[g][1]       = bus[g].err_p1;
        assign mwe[g]          = bus[g].mem_we;
        assign ma[g]           = bus[g].mem_a;
        assign mwd[g]          = bus[g].mem_wd;
        assign we_sh[g]        = mwe[g] << ma[g][1:0];
        assign wd_sh[g]        = mwd[g] << {ma[g][1:0], 3'b000};
        assign bus[g].mem_rd   = mem[g][ma[g][9:2]];
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_clr) begin
                for (int i = 0; i < 256; i++) mem[g][i] <= 32'h0;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (we_sh[g][k]) mem[g][ma[g][9:2]][8*k +: 8] <= wd_sh[g][8*k +: 8];
            end
        end
    end

    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic [31:0] a;
        logic [31:0] v;
        logic [3:0]  xwe;
        logic [31:0] xrd;
        logic        xerr;
    } vec_t;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] rd;
        logic        err;
    } rsp_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drv(input int d, input int p, input logic r, input logic w,
                       input logic [1:0] s, input logic [31:0] a, input logic [31:0] v);
        req[d][p] = r;
        wen[d][p] = w;
        siz[d][p] = s;
        adr[d][p] = a;
        wdt[d][p] = v;
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst_s[d] = 1'b1;
        repeat (2) @(negedge clk);
        rst_s[d] = 1'b0;
    endtask

    task automatic rand_run(input int d, input int ncyc);
        int          wv, last, next_free, win, nb, r;
        bit          gp [2];
        bit          err;
        logic [31:0] a, rd;
        rsp_t        q[$];
        rsp_t        e;
        wv        = (d == 0) ? 0 : 3;
        last      = 1;
        next_free = 0;
        gp[0]     = 1'b0;
        gp[1]     = 1'b0;
        for (int i = 0; i < 1024; i++) mb[i] = 8'h0;
        do_reset(d);
        for (int c = 0; c < ncyc + 8; c++) begin
            if (c > 0) @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (gp[p]) req[d][p] = 1'b0;
                gp[p] = 1'b0;
                if (c >= ncyc) begin
                    req[d][p] = 1'b0;
                end else if (!req[d][p] && $urandom_range(0, 3) != 0) begin
                    r = $urandom_range(0, 9);
                    a = 32'h200 + 32'($urandom_range(0, 32'h1FF));
                    siz[d][p] = (r == 0) ? 2'b11 : 2'(r % 3);
                    if ($urandom_range(0, 3) != 0) begin
                        if (siz[d][p] == 2'b01) a[0] = 1'b0;
                        if (siz[d][p] == 2'b10) a[1:0] = 2'b00;
                    end
                    req[d][p] = 1'b1;
                    wen[d][p] = 1'($urandom_range(0, 1));
                    adr[d][p] = a;
                    wdt[d][p] = $urandom;
                end
            end
            #1;
            win = -1;
            if (c >= next_free) begin
                if (req[d][0] && req[d][1]) win = 1 - last;
                else if (req[d][0])         win = 0;
                else if (req[d][1])         win = 1;
            end
            chk("rnd_gnt0", gnt[d][0], win == 0);
            chk("rnd_gnt1", gnt[d][1], win == 1);
            if (q.size() > 0 && q[0].due == c) begin
                e = q.pop_front();
                chk("rnd_rv_own",    rv[d][e.port], 1);
                chk("rnd_rv_other",  rv[d][1-e.port], 0);
                chk("rnd_rdata",     rdt[d][e.port], e.rd);
                chk("rnd_err",       erx[d][e.port], e.err);
                chk("rnd_rd_other",  rdt[d][1-e.port], 0);
            end else begin
                chk("rnd_rv0_idle", rv[d][0], 0);
                chk("rnd_rv1_idle", rv[d][1], 0);
            end
            if (win >= 0) begin
                last      = win;
                next_free = c + wv + 1;
                gp[win]   = 1'b1;
                a         = adr[d][win];
                if (siz[d][win] == 2'b11) begin
                    err = 1'b1;
                    nb  = 0;
                end else begin
                    nb  = 1 << siz[d][win];
                    err = (a % nb) != 0;
                end
                rd = 32'h0;
                if (!err && !wen[d][win])
                    rd = {mb[{a[31:2], 2'b11}], mb[{a[31:2], 2'b10}],
                          mb[{a[31:2], 2'b01}], mb[{a[31:2], 2'b00}]};
                if (!err && wen[d][win])
                    for (int i = 0; i < nb; i++) mb[a + i] = wdt[d][win][8*i +: 8];
                q.push_back('{due: c + wv + 2, port: win, rd: rd, err: err});
            end
        end
        chk("rnd_queue_drained", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv [12];
        int   port;
        tv[0]  = '{1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
        tv[1]  = '{1'b0, 2'b10, 32'h10, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
        tv[2]  = '{1'b1, 2'b01, 32'h22, 32'h1234ABCD, 4'b0011, 32'h0,        1'b0};
        tv[3]  = '{1'b1, 2'b00, 32'h13, 32'h7777775A, 4'b0001, 32'h0,        1'b0};
        tv[4]  = '{1'b0, 2'b10, 32'h20, 32'h0,        4'b0000, 32'hABCD0000, 1'b0};
        tv[5]  = '{1'b0, 2'b10, 32'h10, 32'h0,        4'b0000, 32'h5AADBEEF, 1'b0};
        tv[6]  = '{1'b1, 2'b10, 32'h06, 32'h11111111, 4'b0000, 32'h0,        1'b1};
        tv[7]  = '{1'b0, 2'b11, 32'h08, 32'h0,        4'b0000, 32'h0,        1'b1};
        tv[8]  = '{1'b0, 2'b01, 32'h21, 32'h0,        4'b0000, 32'h0,        1'b1};
        tv[9]  = '{1'b0, 2'b00, 32'h13, 32'h0,        4'b0000, 32'h5AADBEEF, 1'b0};
        tv[10] = '{1'b1, 2'b01, 32'h23, 32'hFFFFFFFF, 4'b0000, 32'h0,        1'b1};
        tv[11] = '{1'b0, 2'b01, 32'h22, 32'h0,        4'b0000, 32'hABCD0000, 1'b0};

        rst_s[0] = 1'b1;
        rst_s[1] = 1'b1;
        mem_clr  = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) drv(d, p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(posedge clk);
        #1 mem_clr = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) drv(d, p, 1'b1, 1'b1, 2'b10, 32'h40, 32'h5);

        // Reset state: grants forced low even with requests pending
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_gnt0", d), gnt[d][0], 0);
            chk($sformatf("rst%0d_gnt1", d), gnt[d][1], 0);
            chk($sformatf("rst%0d_mem_we", d), mwe[d], 0);
            chk($sformatf("rst%0d_mem_a", d), ma[d], 0);
            chk($sformatf("rst%0d_mem_wd", d), mwd[d], 0);
            chk($sformatf("rst%0d_rv0", d), rv[d][0], 0);
            chk($sformatf("rst%0d_rv1", d), rv[d][1], 0);
            chk($sformatf("rst%0d_rdata0", d), rdt[d][0], 0);
            chk($sformatf("rst%0d_err0", d), erx[d][0], 0);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            req[d][0] = 1'b0;
            req[d][1] = 1'b0;
            rst_s[d]  = 1'b0;
        end

        // Table vectors: single accesses on port 0 of the WAIT=0 instance
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drv(0, 0, 1'b1, tv[i].w, tv[i].s, tv[i].a, tv[i].v);
            #1;
            chk($sformatf("tv%0d_gnt0", i), gnt[0][0], 1);
            chk($sformatf("tv%0d_gnt1", i), gnt[0][1], 0);
            @(negedge clk);
            req[0][0] = 1'b0;
            #1;
            chk($sformatf("tv%0d_mem_we", i), mwe[0], tv[i].xwe);
            chk($sformatf("tv%0d_mem_a", i), ma[0], tv[i].a);
            chk($sformatf("tv%0d_mem_wd", i), mwd[0], tv[i].v);
            @(negedge clk);
            #1;
            chk($sformatf("tv%0d_rv0", i), rv[0][0], 1);
            chk($sformatf("tv%0d_rv1", i), rv[0][1], 0);
            chk($sformatf("tv%0d_rdata0", i), rdt[0][0], tv[i].xrd);
            chk($sformatf("tv%0d_err0", i), erx[0][0], tv[i].xerr);
        end

        // Back-to-back store then load at WAIT=0
        @(negedge clk);
        drv(0, 0, 1'b1, 1'b1, 2'b10, 32'h30, 32'h12345678);
        #1 chk("b2b_gnt_store", gnt[0][0], 1);
        @(negedge clk);
        drv(0, 0, 1'b1, 1'b0, 2'b10, 32'h30, 32'h0);
        #1;
        chk("b2b_gnt_load", gnt[0][0], 1);
        chk("b2b_we_store", mwe[0], 4'b1111);
        @(negedge clk);
        req[0][0] = 1'b0;
        #1;
        chk("b2b_we_load", mwe[0], 0);
        chk("b2b_rv_store", rv[0][0], 1);
        chk("b2b_rd_store", rdt[0][0], 0);
        @(negedge clk);
        #1;
        chk("b2b_rv_load", rv[0][0], 1);
        chk("b2b_rd_load", rdt[0][0], 32'h12345678);
        chk("b2b_err_load", erx[0][0], 0);
        @(negedge clk);
        #1 chk("b2b_rv_after", rv[0][0], 0);

        // Both ports request every cycle right after reset: strict alternation
        do_reset(0);
        drv(0, 0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        drv(0, 1, 1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 8) begin
                req[0][0] = 1'b0;
                req[0][1] = 1'b0;
            end
            #1;
            chk($sformatf("alt%0d_gnt0", k), gnt[0][0], (k < 8) && (k % 2 == 0));
            chk($sformatf("alt%0d_gnt1", k), gnt[0][1], (k < 8) && (k % 2 == 1));
            if (k >= 2) begin
                port = (k - 2) % 2;
                chk($sformatf("alt%0d_rv_own", k), rv[0][port], 1);
                chk($sformatf("alt%0d_rv_other", k), rv[0][1-port], 0);
                chk($sformatf("alt%0d_rdata", k), rdt[0][port],
                    (port == 0) ? 32'h5AADBEEF : 32'hABCD0000);
            end else begin
                chk($sformatf("alt%0d_rv0", k), rv[0][0], 0);
                chk($sformatf("alt%0d_rv1", k), rv[0][1], 0);
            end
        end

        // WAIT=3: store from p0 holds the bus 4 cycles while p1 waits to load it back
        @(negedge clk);
        drv(1, 0, 1'b1, 1'b1, 2'b10, 32'h40, 32'hCAFEF00D);
        drv(1, 1, 1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
        #1;
        chk("w3_gnt0", gnt[1][0], 1);
        chk("w3_gnt1_tie", gnt[1][1], 0);
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            if (j == 1) req[1][0] = 1'b0;
            if (j == 5) req[1][1] = 1'b0;
            #1;
            if (j <= 4) begin
                chk($sformatf("w3_c%0d_mem_a", j), ma[1], 32'h40);
                chk($sformatf("w3_c%0d_mem_wd", j), mwd[1], 32'hCAFEF00D);
                chk($sformatf("w3_c%0d_mem_we", j), mwe[1], (j == 4) ? 4'b1111 : 4'b0000);
                chk($sformatf("w3_c%0d_gnt1", j), gnt[1][1], j == 4);
                chk($sformatf("w3_c%0d_rv0", j), rv[1][0], 0);
            end else if (j == 5) begin
                chk("w3_rv0", rv[1][0], 1);
                chk("w3_rd0", rdt[1][0], 0);
                chk("w3_err0", erx[1][0], 0);
                chk("w3_rv1_none", rv[1][1], 0);
                chk("w3_load_mem_we", mwe[1], 0);
            end else if (j < 9) begin
                chk($sformatf("w3_c%0d_rv1", j), rv[1][1], 0);
            end else begin
                chk("w3_rv1", rv[1][1], 1);
                chk("w3_rd1", rdt[1][1], 32'hCAFEF00D);
                chk("w3_rv0_none", rv[1][0], 0);
            end
        end

        // Reset asserted in the second access cycle of a WAIT=3 store from p0
        @(negedge clk);
        drv(1, 0, 1'b1, 1'b1, 2'b10, 32'h50, 32'h99999999);
        #1 chk("mid_gnt0", gnt[1][0], 1);
        @(negedge clk);
        req[1][0] = 1'b0;
        #1 chk("mid_c1_mem_we", mwe[1], 0);
        @(negedge clk);
        drv(1, 0, 1'b1, 1'b0, 2'b10, 32'h50, 32'h0);
        drv(1, 1, 1'b1, 1'b0, 2'b10, 32'h54, 32'h0);
        #1 chk("mid_pre_mem_a", ma[1], 32'h50);
        #1 rst_s[1] = 1'b1;
        #1;
        chk("mid_rst_mem_we", mwe[1], 0);
        chk("mid_rst_mem_a", ma[1], 0);
        chk("mid_rst_mem_wd", mwd[1], 0);
        chk("mid_rst_gnt0", gnt[1][0], 0);
        chk("mid_rst_gnt1", gnt[1][1], 0);
        @(negedge clk);
        rst_s[1] = 1'b0;
        #1;
        chk("mid_post_gnt0", gnt[1][0], 1);
        chk("mid_post_gnt1", gnt[1][1], 0);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (j == 1) begin
                req[1][0] = 1'b0;
                req[1][1] = 1'b0;
            end
            #1;
            chk($sformatf("mid_c%0d_rv0", j), rv[1][0], 0);
            chk($sformatf("mid_c%0d_rv1", j), rv[1][1], 0);
        end
        @(negedge clk);
        #1;
        chk("mid_load_rv0", rv[1][0], 1);
        chk("mid_load_rd0", rdt[1][0], 0);
        chk("mid_no_write", mem[1][20], 0);

        // Randomised traffic against the reference model
        rand_run(0, 400);
        rand_run(1, 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (combinational read, byte-lane write enables, write on posedge) between two requesters: port 0 = core load/store unit, port 1 = DMA/debug loader.
- Round-robin arbitration, one registered access stage with optional wait states, alignment checking and a one-cycle response per access.
- Drives the memory's we[3:0], a, wd; receives rd.

Parameters:
- WAIT, 0, extra cycles each access is held on the memory bus (0..15); access stage lasts WAIT+1 cycles.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_p0 / req_p1  in  1  request valid, held until granted
- we_p0 / we_p1  in  1  1 = store, 0 = load
- size_p0 / size_p1  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as error)
- addr_p0 / addr_p1  in  32  byte address
- wdata_p0 / wdata_p1  in  32  store data, unshifted (byte in [7:0], half in [15:0])
- gnt_p0 / gnt_p1  out  1  request accepted this cycle (combinational)
- resp_valid_p0 / resp_valid_p1  out  1  one-cycle response strobe
- rdata_p0 / rdata_p1  out  32  raw memory word for loads, 0 for stores/errors
- err_p0 / err_p1  out  1  access was misaligned/reserved, valid with resp_valid
- mem_we  out  4  to memory: word 4'b1111, half 4'b0011, byte 4'b0001, else 0
- mem_a  out  32  to memory address
- mem_wd  out  32  to memory write data
- mem_rd  in  32  from memory read data

Behaviour:
- Reset (async, immediate): state IDLE, wait counter 0, rr pointer = 1 (port 0 wins first contention), mem_we/mem_a/mem_wd = 0, all resp_valid/rdata/err = 0, gnt forced 0 while reset high. Access in flight is dropped, no response issued.
- States: IDLE, ACCESS.
- Grant: allowed when state IDLE or ACCESS in its final cycle (counter == WAIT). Only one requester -> it wins. Both -> port other than last-granted wins; pointer updates on every grant. Requester fields sampled only in the grant cycle.
- On grant edge: latch port id, we, size, addr, wdata, err flag; enter/stay ACCESS with counter 0. No grant at final cycle -> IDLE.
- ACCESS: mem_a = latched addr, mem_wd = latched wdata, held stable all WAIT+1 cycles. mem_we nonzero only in the final cycle (exactly one write edge), and only if store and not err. Non-final cycles: counter increments.
- Error when: size 11; half with addr[0]=1; word with addr[1:0]!=0. Error access: no write, rdata 0, err 1.
- Response: at the final-cycle edge, the owning port gets resp_valid=1 for exactly the next cycle; loads return mem_rd sampled at that edge; stores return rdata 0. Non-owning port's resp outputs stay 0.
- Throughput WAIT=0: one access per cycle back-to-back; load latency grant-cycle + 2 to resp_valid.
- Simultaneous grant and response to the same port in one cycle is legal.
- No back-pressure on responses; requesters must accept resp_valid.

Test Plan:
- WAIT=0, p0 store word 0xDEADBEEF @0x10 then load @0x10 -> grants on consecutive cycles, mem_we=1111 for one cycle, load resp_valid_p0 2 cycles after its grant, rdata_p0=0xDEADBEEF, err 0.
- Both ports request every cycle after reset -> grants alternate p0,p1,p0,p1; each response to the correct port only.
- p1 half store 0xABCD @0x22, byte store 0x5A @0x13 -> mem_we=0011 then 0001, mem_wd low bits 0xABCD/0x5A; reload word 0x20 shows 0xABCD in [31:16].
- Misaligned word @0x06 and size 11 from p0 -> mem_we stays 0, resp_valid_p0 with err_p0=1, rdata_p0=0.
- WAIT=3, p0 store -> mem_a held 4 cycles, mem_we nonzero only 4th cycle, next gnt not before 4th cycle, response cycle after.
- Assert reset mid-ACCESS (WAIT=3, cycle 2) -> mem_we/outputs 0 immediately, no resp_valid, next contention grants p0.
